// File: rtl/adventure_pkg.sv
// Shared definitions for the adventure game core: room codes, move directions
// and the input sequencer's controller states.
package adventure_pkg;

  localparam logic [2:0] ROOM_C   = 3'b000;
  localparam logic [2:0] ROOM_T   = 3'b001;
  localparam logic [2:0] ROOM_R   = 3'b010;
  localparam logic [2:0] ROOM_S   = 3'b011;
  localparam logic [2:0] ROOM_D   = 3'b100;
  localparam logic [2:0] ROOM_WIN = 3'b101;
  localparam logic [2:0] ROOM_DIE = 3'b110;

  typedef enum logic [1:0] {
    DIR_N = 2'd0,
    DIR_S = 2'd1,
    DIR_E = 2'd2,
    DIR_W = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    ST_PLAY  = 2'd0,
    ST_OVER  = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  function automatic logic is_terminal(input logic [2:0] room);
    return (room == ROOM_WIN) || (room == ROOM_DIE);
  endfunction

endpackage

// File: rtl/move_fifo.sv
// Synchronous FIFO for queued moves. Pointers carry one extra wrap bit so
// full and empty are distinguished without a separate occupancy counter.
module move_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr;
  logic              do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees a slot, so a push into a full queue is legal then.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/adventure_move_ctrl.sv
// Input sequencer: button edge detect and priority, move queue toward the
// game core, and the PLAY/OVER/FLUSH controller that freezes on a terminal room.
module adventure_move_ctrl
  import adventure_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             N,
  input  logic             S,
  input  logic             E,
  input  logic             W,
  input  logic [2:0]       room,
  input  logic             restart,
  output logic             mv_valid,
  output logic [1:0]       mv_dir,
  input  logic             mv_ready,
  output logic             game_over,
  output logic             win,
  output logic [CNT_W-1:0] move_count,
  output logic             drop
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_e     state;
  logic [3:0] btn, prev_btn, press;
  logic [1:0] sel_dir, head;
  logic       play, any_press, multi, push, pop, full, empty, drop_nxt;

  assign btn       = {W, E, S, N};
  assign press     = btn & ~prev_btn;
  assign any_press = |press;
  assign multi     = (press & (press - 4'd1)) != 4'd0;
  assign play      = (state == ST_PLAY);

  always_comb begin
    sel_dir = DIR_W;
    if (press[0])      sel_dir = DIR_N;
    else if (press[1]) sel_dir = DIR_S;
    else if (press[2]) sel_dir = DIR_E;
  end

  assign mv_valid = play & ~empty;
  assign mv_dir   = mv_valid ? head : DIR_N;
  assign pop      = mv_valid & mv_ready;
  assign push     = play & any_press & (~full | pop);
  assign drop_nxt = play & any_press & (multi | (full & ~pop));

  move_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (2)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (state == ST_FLUSH),
    .push  (push),
    .pop   (pop),
    .din   (sel_dir),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_PLAY;
      prev_btn   <= 4'b1111;
      game_over  <= 1'b0;
      win        <= 1'b0;
      move_count <= '0;
      drop       <= 1'b0;
    end else begin
      prev_btn <= btn;
      drop     <= drop_nxt;
      if (pop) move_count <= sat_inc(move_count);
      case (state)
        ST_PLAY: begin
          if (is_terminal(room)) begin
            state     <= ST_OVER;
            game_over <= 1'b1;
            win       <= (room == ROOM_WIN);
          end
        end
        ST_OVER: begin
          if (restart) begin
            state     <= ST_FLUSH;
            game_over <= 1'b0;
          end
        end
        ST_FLUSH: begin
          state      <= ST_PLAY;
          move_count <= '0;
          win        <= 1'b0;
          game_over  <= 1'b0;
        end
        default: state <= ST_PLAY;
      endcase
    end
  end

endmodule

// File: tb/tb_adventure_move_ctrl.sv
// Directed bench for adventure_move_ctrl with hand-computed expectations.
module tb_adventure_move_ctrl;
  import adventure_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       N, S, E, W;
  logic [2:0] room;
  logic       restart;
  logic       mv_valid;
  logic [1:0] mv_dir;
  logic       mv_ready;
  logic       game_over;
  logic       win;
  logic [7:0] move_count;
  logic       drop;

  int n_cmp = 0;
  int n_err = 0;

  adventure_move_ctrl #(.DEPTH(4), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .N          (N),
    .S          (S),
    .E          (E),
    .W          (W),
    .room       (room),
    .restart    (restart),
    .mv_valid   (mv_valid),
    .mv_dir     (mv_dir),
    .mv_ready   (mv_ready),
    .game_over  (game_over),
    .win        (win),
    .move_count (move_count),
    .drop       (drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic btns(input logic n, input logic s, input logic e, input logic w);
    N = n; S = s; E = e; W = w;
  endtask

  logic [1:0] exp_dir [4];

  initial begin
    rst_n = 1'b0; restart = 1'b0; mv_ready = 1'b0; room = ROOM_C;
    btns(0, 1, 0, 0);
    step(); step();
    chk("rst_valid", 32'(mv_valid), 0);
    chk("rst_dir", 32'(mv_dir), 0);
    chk("rst_gover", 32'(game_over), 0);
    chk("rst_win", 32'(win), 0);
    chk("rst_count", 32'(move_count), 0);
    chk("rst_drop", 32'(drop), 0);

    // S held through reset: no press
    rst_n = 1'b1;
    step(); step();
    chk("held_no_valid", 32'(mv_valid), 0);
    btns(0, 0, 0, 0); step();
    btns(0, 1, 0, 0); step();
    chk("s_valid", 32'(mv_valid), 1);
    chk("s_dir", 32'(mv_dir), 1);
    btns(0, 0, 0, 0); mv_ready = 1'b1; step();
    mv_ready = 1'b0;
    chk("s_drained", 32'(mv_valid), 0);
    chk("s_count", 32'(move_count), 1);

    // N and E together: N wins, drop once
    btns(1, 0, 1, 0); step();
    chk("ne_valid", 32'(mv_valid), 1);
    chk("ne_dir", 32'(mv_dir), 0);
    chk("ne_drop", 32'(drop), 1);
    step();
    chk("ne_drop_once", 32'(drop), 0);
    btns(0, 0, 0, 0); mv_ready = 1'b1; step();
    mv_ready = 1'b0;
    chk("ne_single", 32'(mv_valid), 0);
    chk("ne_count", 32'(move_count), 2);

    // Five presses into a 4-deep queue with mv_ready low
    btns(1, 0, 0, 0); step();
    btns(0, 1, 0, 0); step();
    btns(0, 0, 1, 0); step();
    btns(0, 0, 0, 1); step();
    chk("fill_no_drop", 32'(drop), 0);
    btns(1, 0, 0, 0); step();
    chk("full_drop", 32'(drop), 1);
    chk("full_head", 32'(mv_dir), 0);
    btns(0, 0, 0, 0); step();
    chk("full_drop_end", 32'(drop), 0);
    exp_dir[0] = 2'd0; exp_dir[1] = 2'd1; exp_dir[2] = 2'd2; exp_dir[3] = 2'd3;
    mv_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain_valid%0d", i), 32'(mv_valid), 1);
      chk($sformatf("drain_dir%0d", i), 32'(mv_dir), 32'(exp_dir[i]));
      step();
    end
    mv_ready = 1'b0;
    chk("drain_empty", 32'(mv_valid), 0);
    chk("drain_count", 32'(move_count), 6);

    // Full queue, press coincides with a handshake
    btns(1, 0, 0, 0); step();
    btns(0, 1, 0, 0); step();
    btns(0, 0, 1, 0); step();
    btns(0, 0, 0, 1); step();
    btns(1, 0, 0, 0); mv_ready = 1'b1; step();
    btns(0, 0, 0, 0);
    chk("co_no_drop", 32'(drop), 0);
    chk("co_count", 32'(move_count), 7);
    exp_dir[0] = 2'd1; exp_dir[1] = 2'd2; exp_dir[2] = 2'd3; exp_dir[3] = 2'd0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("co_dir%0d", i), 32'(mv_dir), 32'(exp_dir[i]));
      step();
    end
    mv_ready = 1'b0;
    chk("co_empty", 32'(mv_valid), 0);
    chk("co_count_end", 32'(move_count), 11);

    // WIN room with two queued moves and a same-cycle handshake
    btns(1, 0, 0, 0); step();
    btns(0, 1, 0, 0); step();
    btns(0, 0, 0, 0);
    room = ROOM_WIN; mv_ready = 1'b1; step();
    room = ROOM_C; mv_ready = 1'b0;
    chk("win_gover", 32'(game_over), 1);
    chk("win_win", 32'(win), 1);
    chk("win_valid", 32'(mv_valid), 0);
    chk("win_count", 32'(move_count), 12);
    btns(0, 0, 1, 0); step();
    btns(0, 0, 0, 0);
    chk("over_no_drop", 32'(drop), 0);
    chk("over_hold", 32'(game_over), 1);

    // Restart: FLUSH then PLAY with everything cleared
    restart = 1'b1; step();
    restart = 1'b0;
    chk("flush_valid", 32'(mv_valid), 0);
    step();
    chk("play_valid", 32'(mv_valid), 0);
    chk("play_count", 32'(move_count), 0);
    chk("play_gover", 32'(game_over), 0);
    chk("play_win", 32'(win), 0);
    btns(0, 0, 0, 1); step();
    btns(0, 0, 0, 0);
    chk("rs_valid", 32'(mv_valid), 1);
    chk("rs_dir", 32'(mv_dir), 3);
    room = ROOM_DIE; step();
    room = ROOM_C;
    chk("die_gover", 32'(game_over), 1);
    chk("die_win", 32'(win), 0);
    chk("die_valid", 32'(mv_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
